// File: rtl/div_pkg.sv
// Shared types and constants for the sequential 32/16 restoring divider.
package div_pkg;
  localparam int DIV_W    = 16;
  localparam int DIVD_W   = 32;
  localparam int DIV_ITER = 16;
  localparam int CNT_W    = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/div_rq_reg.sv
// Partial-remainder / quotient datapath: load, one restoring step per cycle, clear,
// and an optional negation of either result on the final step.
module div_rq_reg
  import div_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             clear,
  input  logic             fix_q,
  input  logic             fix_r,
  input  logic [DIV_W-1:0] load_hi,
  input  logic [DIV_W-1:0] load_lo,
  input  logic [DIV_W-1:0] load_dvs,
  output logic [DIV_W-1:0] quo,
  output logic [DIV_W-1:0] rem
);

  logic [DIV_W:0]   rem_q;
  logic [DIV_W-1:0] lo_q;
  logic [DIV_W-1:0] dvs_q;
  logic [DIV_W:0]   sh_rem;
  logic [DIV_W:0]   diff;
  logic             ge;
  logic [DIV_W:0]   nrem;
  logic [DIV_W-1:0] nlo;
  logic             unused_rem_msb;

  // Remainder stays below the divisor after every step, so bit 16 only matters
  // transiently in the shifted value, never in the stored one.
  assign unused_rem_msb = rem_q[DIV_W];

  always_comb begin
    sh_rem = {rem_q[DIV_W-1:0], lo_q[DIV_W-1]};
    diff   = sh_rem - {1'b0, dvs_q};
    ge     = (sh_rem >= {1'b0, dvs_q});
    nrem   = ge ? diff : sh_rem;
    nlo    = {lo_q[DIV_W-2:0], ge};
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      rem_q <= '0;
      lo_q  <= '0;
      dvs_q <= '0;
    end else if (load) begin
      rem_q <= {1'b0, load_hi};
      lo_q  <= load_lo;
      dvs_q <= load_dvs;
    end else if (step) begin
      rem_q <= fix_r ? {1'b0, -nrem[DIV_W-1:0]} : nrem;
      lo_q  <= fix_q ? -nlo : nlo;
    end
  end

  assign quo = lo_q;
  assign rem = rem_q[DIV_W-1:0];

endmodule

// File: rtl/divisor_seq.sv
// Sequential 32/16 divider: FSM, iteration counter and Start/Busy/Done handshake.
// Define DIV_SIGNED_EN to add the Sinal port and two's-complement operation.
module divisor_seq
  import div_pkg::*;
(
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  input  logic [DIVD_W-1:0] Dividendo,
  input  logic [DIV_W-1:0]  Divisor,
`ifdef DIV_SIGNED_EN
  input  logic              Sinal,
`endif
  output logic [DIV_W-1:0]  Quociente,
  output logic [DIV_W-1:0]  Resto,
  output logic              Ovf,
  output logic              Busy,
  output logic              Done
);

  // state | meaning
  // IDLE  | waiting for Start; operands captured on the accepting edge
  // CALC  | one restoring step per cycle, 16 cycles
  // DONE  | one-cycle completion pulse, results held
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             load, clear, step, last;
  logic             fix_q, fix_r;
  logic             ovf_in;
  logic [DIVD_W-1:0] dvd_mag;
  logic [DIV_W-1:0]  dvs_mag;

`ifdef DIV_SIGNED_EN
  logic              dvd_neg, dvs_neg, q_neg_in, sign_ovf;
  logic              q_neg_q, r_neg_q;
  logic [DIVD_W-1:0] lim_pos, lim_neg;

  assign dvd_neg  = Sinal & Dividendo[DIVD_W-1];
  assign dvs_neg  = Sinal & Divisor[DIV_W-1];
  assign dvd_mag  = dvd_neg ? -Dividendo : Dividendo;
  assign dvs_mag  = dvs_neg ? -Divisor : Divisor;
  assign q_neg_in = dvd_neg ^ dvs_neg;
  // Quotient magnitude must stay within 0x7FFF (positive) or 0x8000 (negative).
  assign lim_pos  = {1'b0, dvs_mag, 15'b0};
  assign lim_neg  = lim_pos + {16'b0, dvs_mag};
  assign sign_ovf = Sinal & (dvd_mag >= (q_neg_in ? lim_neg : lim_pos));

  always_ff @(posedge Clk) begin
    if (!Rst || clear) begin
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else if (load) begin
      q_neg_q <= q_neg_in;
      r_neg_q <= dvd_neg;
    end
  end

  assign fix_q  = last & q_neg_q;
  assign fix_r  = last & r_neg_q;
  assign ovf_in = (dvs_mag == '0) || (dvd_mag[DIVD_W-1:DIV_W] >= dvs_mag) || sign_ovf;
`else
  assign dvd_mag = Dividendo;
  assign dvs_mag = Divisor;
  assign fix_q   = 1'b0;
  assign fix_r   = 1'b0;
  assign ovf_in  = (dvs_mag == '0) || (dvd_mag[DIVD_W-1:DIV_W] >= dvs_mag);
`endif

  assign last = (state_q == CALC) && (cnt_q == CNT_W'(DIV_ITER - 1));

  always_ff @(posedge Clk) begin
    if (!Rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    clear   = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          if (ovf_in) begin
            clear   = 1'b1;
            state_d = DONE;
          end else begin
            load    = 1'b1;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        step = 1'b1;
        if (last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      cnt_q <= '0;
      Ovf   <= 1'b0;
    end else begin
      if (load || clear) cnt_q <= '0;
      else if (step)     cnt_q <= cnt_q + CNT_W'(1);
      if (load || clear) Ovf <= clear;
    end
  end

  div_rq_reg u_rq (
    .clk      (Clk),
    .rst_n    (Rst),
    .load     (load),
    .step     (step),
    .clear    (clear),
    .fix_q    (fix_q),
    .fix_r    (fix_r),
    .load_hi  (dvd_mag[DIVD_W-1:DIV_W]),
    .load_lo  (dvd_mag[DIV_W-1:0]),
    .load_dvs (dvs_mag),
    .quo      (Quociente),
    .rem      (Resto)
  );

  assign Busy = (state_q == CALC);
  assign Done = (state_q == DONE);

endmodule

// File: tb/tb_divisor_seq.sv
// Directed self-checking bench for divisor_seq (unsigned; signed cases with DIV_SIGNED_EN).
module tb_divisor_seq;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Start;
  logic [31:0] Dividendo;
  logic [15:0] Divisor;
`ifdef DIV_SIGNED_EN
  logic        Sinal;
`endif
  logic [15:0] Quociente;
  logic [15:0] Resto;
  logic        Ovf;
  logic        Busy;
  logic        Done;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  divisor_seq dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Start     (Start),
    .Dividendo (Dividendo),
    .Divisor   (Divisor),
`ifdef DIV_SIGNED_EN
    .Sinal     (Sinal),
`endif
    .Quociente (Quociente),
    .Resto     (Resto),
    .Ovf       (Ovf),
    .Busy      (Busy),
    .Done      (Done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launches one division and follows it to Done; latency counted in cycles after the accepting edge.
  task automatic do_div(input string tag, input logic [31:0] dvd, input logic [15:0] dvs,
                        input logic [15:0] eq, input logic [15:0] er, input logic eo, input int elat);
    int lat, busy_cnt, both;
    lat = 0; busy_cnt = 0; both = 0;
    @(negedge Clk);
    Dividendo = dvd; Divisor = dvs; Start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge Clk);
      Start = 1'b0;
      if (Busy && Done) both++;
      if (Busy) busy_cnt++;
      if (Done) begin lat = k; break; end
    end
    chk({tag, " latency"}, lat, elat);
    chk({tag, " busy cycles"}, busy_cnt, elat - 1);
    chk({tag, " busy&done"}, both, 0);
    chk({tag, " quotient"}, Quociente, eq);
    chk({tag, " remainder"}, Resto, er);
    chk({tag, " ovf"}, Ovf, eo);
    @(negedge Clk);
    chk({tag, " done pulse width"}, Done, 1'b0);
    chk({tag, " quotient held"}, Quociente, eq);
  endtask

  initial begin
    int first_done, done_cnt, busy18, busy19, second_done;
    Rst = 1'b0; Start = 1'b0; Dividendo = '0; Divisor = '0;
`ifdef DIV_SIGNED_EN
    Sinal = 1'b0;
`endif
    repeat (3) @(negedge Clk);
    chk("reset quotient", Quociente, 0);
    chk("reset remainder", Resto, 0);
    chk("reset ovf", Ovf, 0);
    chk("reset busy", Busy, 0);
    chk("reset done", Done, 0);
    Rst = 1'b1;

    do_div("100/7",          32'd100,        16'd7,      16'd14,     16'd2, 1'b0, 17);
    do_div("max quotient",   32'hFFFE0001,   16'hFFFF,   16'hFFFF,   16'd0, 1'b0, 17);
    do_div("ovf hi>=dvs",    32'h00010000,   16'd1,      16'd0,      16'd0, 1'b1, 1);
    do_div("ovf dvs=0",      32'h12345678,   16'd0,      16'd0,      16'd0, 1'b1, 1);
    do_div("hi just below",  32'h0006FFFF,   16'd7,      16'hFFFF,   16'd6, 1'b0, 17);

    // Reset during the eighth iteration.
    @(negedge Clk);
    Dividendo = 32'hDEADBEEF; Divisor = 16'hF000; Start = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge Clk);
      Start = 1'b0;
    end
    Rst = 1'b0;
    @(negedge Clk);
    chk("midreset quotient", Quociente, 0);
    chk("midreset remainder", Resto, 0);
    chk("midreset ovf", Ovf, 0);
    chk("midreset busy", Busy, 0);
    chk("midreset done", Done, 0);
    Rst = 1'b1;
    do_div("after reset 1000/10", 32'd1000, 16'd10, 16'd100, 16'd0, 1'b0, 17);

    // Start pulse with other operands in the middle of CALC must be ignored.
    first_done = 0; done_cnt = 0;
    @(negedge Clk);
    Dividendo = 32'd123456; Divisor = 16'd1000; Start = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      @(negedge Clk);
      Start = 1'b0;
      if (Done) begin
        done_cnt++;
        if (first_done == 0) first_done = k;
      end
      if (k == 5) begin Start = 1'b1; Dividendo = 32'hFFFFFFFF; Divisor = 16'd1; end
    end
    chk("ignored start done count", done_cnt, 1);
    chk("ignored start latency", first_done, 17);
    chk("ignored start quotient", Quociente, 16'd123);
    chk("ignored start remainder", Resto, 16'd456);
    chk("ignored start ovf", Ovf, 0);

    // Start held through DONE is accepted again in the following IDLE cycle.
    first_done = 0; second_done = 0; busy18 = -1; busy19 = -1;
    @(negedge Clk);
    Dividendo = 32'd200; Divisor = 16'd9; Start = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      @(negedge Clk);
      if (k == 18) busy18 = int'(Busy);
      if (k == 19) begin busy19 = int'(Busy); Start = 1'b0; end
      if (Done) begin
        if (first_done == 0) first_done = k;
        else if (second_done == 0) second_done = k;
      end
    end
    chk("held start first done", first_done, 17);
    chk("held start idle gap busy", busy18, 0);
    chk("held start relaunch busy", busy19, 1);
    chk("held start second done", second_done, 35);
    chk("held start quotient", Quociente, 16'd22);
    chk("held start remainder", Resto, 16'd2);

`ifdef DIV_SIGNED_EN
    Sinal = 1'b1;
    do_div("signed -100/7",    32'hFFFFFF9C, 16'd7,      16'hFFF2, 16'hFFFE, 1'b0, 17);
    do_div("signed 100/-7",    32'd100,      16'hFFF9,   16'hFFF2, 16'd2,    1'b0, 17);
    do_div("signed -32768/1",  32'hFFFF8000, 16'd1,      16'h8000, 16'd0,    1'b0, 17);
    do_div("signed 32768/1",   32'h00008000, 16'd1,      16'd0,    16'd0,    1'b1, 1);
    Sinal = 1'b0;
    do_div("unsigned 32768/1", 32'h00008000, 16'd1,      16'h8000, 16'd0,    1'b0, 17);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
